// File: rtl/mem_access_ctrl.sv
// Load/store front-end between the MIPS datapath and word-addressed memory.
// Translates byte addresses to word indices, rejects bad accesses, and sequences one strobe per request.
module mem_access_ctrl #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] SEG_BASE        = 'h0040_0000,
  parameter int                    MEM_DEPTH_WORDS = 1024,
  parameter int                    WAIT_STATES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam int                    CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] DEPTH    = ADDR_WIDTH'(MEM_DEPTH_WORDS);

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  addr_err;

  // Offset wraps for addresses below the base, so the explicit below-base test is still needed.
  always_comb begin
    offset   = req_addr - SEG_BASE;
    idx      = offset >> 2;
    addr_err = (req_addr[1:0] != 2'b00) || (req_addr < SEG_BASE) || (idx >= DEPTH);
  end

  assign req_ready = reset && (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we <= req_we;
            if (addr_err) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= idx;
              mem_wdata <= req_wdata;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (WAIT_STATES == 0) begin
            resp_valid <= 1'b1;
            resp_rdata <= lat_we ? '0 : mem_rdata;
            state      <= RESP;
          end else begin
            wait_cnt <= CNT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            resp_valid <= 1'b1;
            resp_rdata <= lat_we ? '0 : mem_rdata;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level model, per-cycle compare,
// directed boundary cases, randomized traffic and an asynchronous reset abort.
module tb_mem_access_ctrl;

  localparam int              WS    = 2;
  localparam longint unsigned SEG   = 64'h0040_0000;
  localparam longint unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;
  logic check_en = 1'b0;

  mem_access_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEG_BASE(32'h0040_0000),
    .MEM_DEPTH_WORDS(1024), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // A request is bad if misaligned, below the segment, or past the last word.
  function automatic logic addr_bad(input logic [31:0] a);
    longint unsigned ua = 64'(a);
    if (ua % 4 != 0) return 1'b1;
    if (ua < SEG) return 1'b1;
    return ((ua - SEG) / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] base = 32'h0040_0000;
    case ($urandom_range(0, 5))
      0: return base + 32'(4 * $urandom_range(0, 1023));
      1: return ($urandom_range(0, 1) == 1) ? base + 32'(4 * 1023) : base;
      2: return base + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
      3: return base - 32'(4 * $urandom_range(1, 16));
      4: return base + 32'h1000 + 32'(4 * $urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  // Transaction model: counts edges since acceptance instead of tracking controller states.
  logic        m_busy = 1'b0;
  int          m_edges = 0;
  logic        m_err = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_idx = '0;
  logic [31:0] m_wdata = '0;
  logic        m_resp_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_resp_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_edges <= 0; m_err <= 1'b0; m_we <= 1'b0;
      m_idx <= '0; m_wdata <= '0;
      m_resp_valid <= 1'b0; m_rdata <= '0; m_resp_err <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_edges <= 0;
        m_we    <= req_we;
        m_err   <= addr_bad(req_addr);
        m_idx   <= (req_addr - 32'h0040_0000) / 4;
        m_wdata <= req_wdata;
        if (addr_bad(req_addr)) begin
          m_resp_valid <= 1'b1;
          m_resp_err   <= 1'b1;
          m_rdata      <= '0;
        end
      end
    end else if (m_resp_valid) begin
      if (resp_ready) begin
        m_busy <= 1'b0; m_resp_valid <= 1'b0; m_resp_err <= 1'b0; m_rdata <= '0;
      end
    end else if (m_edges == WS) begin
      m_resp_valid <= 1'b1;
      m_rdata      <= m_we ? 32'h0 : mem_rdata;
    end else begin
      m_edges <= m_edges + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  logic exp_en;
  always @(negedge clk) begin
    if (check_en) begin
      exp_en = m_busy && !m_err && !m_resp_valid && (m_edges == 0);
      checkOutput("req_ready", 32'(req_ready), 32'(reset && !m_busy));
      checkOutput("mem_en", 32'(mem_en), 32'(exp_en));
      if (exp_en) begin
        checkOutput("mem_we", 32'(mem_we), 32'(m_we));
        checkOutput("mem_addr", mem_addr, m_idx);
        checkOutput("mem_wdata", mem_wdata, m_wdata);
      end
      checkOutput("resp_valid", 32'(resp_valid), 32'(m_resp_valid));
      checkOutput("resp_error", 32'(resp_error), 32'(m_resp_err));
      checkOutput("resp_rdata", resp_rdata, m_rdata);
    end
  end

  // Issues one request from idle, presents junk requests while busy, then completes the handshake.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input int hold, output int strobes, output logic [31:0] s_addr,
                               output logic s_we, output logic [31:0] s_wdata, output int lat,
                               output logic [31:0] r_data, output logic r_err);
    strobes = 0; s_addr = '0; s_we = 1'b0; s_wdata = '0; lat = -1; r_data = '0; r_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        strobes++; s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
      end
      if (resp_valid) begin
        lat = k; r_data = resp_rdata; r_err = resp_error;
      end
      req_we = 1'b0; req_addr = 32'h0040_0040; req_wdata = 32'hFFFF_0000;
    end
    if (lat < 0) checkOutput("resp_timeout", 32'h0, 32'h1);
    repeat (hold) begin
      @(negedge clk);
      if (mem_en) strobes++;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  int          strobes, lat;
  logic [31:0] s_addr, s_wdata, r_data;
  logic        s_we, r_err;
  logic [31:0] bad_addrs [3];

  initial begin
    bad_addrs[0] = 32'h0040_0002;
    bad_addrs[1] = 32'h003F_FFFC;
    bad_addrs[2] = 32'h0040_1000;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;

    applyStimulus(1'b0, 32'h0040_0008, 32'h0, 5, strobes, s_addr, s_we, s_wdata, lat, r_data, r_err);
    checkOutput("load_strobes", 32'(strobes), 32'd1);
    checkOutput("load_mem_addr", s_addr, 32'd2);
    checkOutput("load_mem_we", 32'(s_we), 32'd0);
    checkOutput("load_latency", 32'(lat), 32'd4);
    checkOutput("load_rdata", r_data, 32'hDEAD_BEEF);
    checkOutput("load_error", 32'(r_err), 32'd0);

    applyStimulus(1'b1, 32'h0040_0000, 32'h1234_5678, 0, strobes, s_addr, s_we, s_wdata, lat, r_data, r_err);
    checkOutput("store_strobes", 32'(strobes), 32'd1);
    checkOutput("store_mem_addr", s_addr, 32'd0);
    checkOutput("store_mem_we", 32'(s_we), 32'd1);
    checkOutput("store_mem_wdata", s_wdata, 32'h1234_5678);
    checkOutput("store_rdata", r_data, 32'h0);
    checkOutput("store_error", 32'(r_err), 32'd0);

    foreach (bad_addrs[i]) begin
      applyStimulus(1'b0, bad_addrs[i], 32'h0, 1, strobes, s_addr, s_we, s_wdata, lat, r_data, r_err);
      checkOutput("err_strobes", 32'(strobes), 32'd0);
      checkOutput("err_latency", 32'(lat), 32'd1);
      checkOutput("err_flag", 32'(r_err), 32'd1);
      checkOutput("err_rdata", r_data, 32'h0);
    end

    applyStimulus(1'b0, 32'h0040_0FFC, 32'h0, 0, strobes, s_addr, s_we, s_wdata, lat, r_data, r_err);
    checkOutput("last_mem_addr", s_addr, 32'd1023);
    checkOutput("last_error", 32'(r_err), 32'd0);

    // Reset dropped mid-WAIT must clear outputs before the next edge and abort the access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0040_0010; mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_error", 32'(resp_error), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    strobes = 0; lat = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_en) strobes++;
      if (resp_valid) lat++;
    end
    checkOutput("post_rst_strobes", 32'(strobes), 32'd0);
    checkOutput("post_rst_resp", 32'(lat), 32'd0);
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);

    repeat (3000) begin
      @(negedge clk);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_we     = $urandom_range(0, 1) == 1;
      req_addr   = pick_addr();
      req_wdata  = $urandom;
      resp_ready = ($urandom_range(0, 3) != 0);
      mem_rdata  = $urandom;
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
